div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_if.sv | 22 ++
 rtl/div_step.sv | 20 ++
 rtl/div.sv | 120 ++++++++++++
 tb/tb_div.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the iterative restoring divider.
// The result bus layout is {remainder, quotient}, matching the HI/LO split.
package div_pkg;

    localparam int REG_BUS_W    = 32;
    localparam int DIV_RESULT_W = 64;
    localparam int DIV_WORK_W   = 65;

    localparam logic [REG_BUS_W-1:0]    ZERO_WORD    = 32'h0000_0000;
    localparam logic [DIV_RESULT_W-1:0] ZERO_RESULT  = 64'h0;
    localparam logic [5:0]              DIV_CNT_DONE = 6'd32;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } div_state_e;

    function automatic logic [REG_BUS_W-1:0] neg32(input logic [REG_BUS_W-1:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the EX stage and the divider.
import div_pkg::*;

interface div_if;
    logic                    signed_div_i;
    logic [REG_BUS_W-1:0]    opdata1_i;
    logic [REG_BUS_W-1:0]    opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DIV_RESULT_W-1:0] result_o;
    logic                    ready_o;

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: 33-bit trial subtract and next working-register mux.
// Bit 64 of the working register is shifted out and never feeds the subtract.
import div_pkg::*;

module div_step (
    input  logic [DIV_WORK_W-2:0] work_i,
    input  logic [REG_BUS_W-1:0]  divisor_i,
    output logic [DIV_WORK_W-1:0] work_o
);
    logic [REG_BUS_W:0] trial;

    always_comb begin
        trial = {1'b0, work_i[63:32]} - {1'b0, divisor_i};
        if (trial[32]) begin
            work_o = {work_i, 1'b0};
        end else begin
            work_o = {trial[31:0], work_i[31:0], 1'b1};
        end
    end
endmodule

// File: rtl/div.sv
// Multi-cycle 32/32 divider: 32 iterations, signed via magnitude + sign fix-up.
// Result is held while start_i stays high; dropping start_i returns to FREE.
import div_pkg::*;

module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [DIV_WORK_W-1:0]   work_q, work_d;
    logic [REG_BUS_W-1:0]    divisor_q, divisor_d;
    logic                    signed_q, signed_d;
    logic                    sign1_q, sign1_d;
    logic                    sign2_q, sign2_d;
    logic [DIV_RESULT_W-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [DIV_WORK_W-1:0]   step_work;
    logic [REG_BUS_W-1:0]    op1_abs, op2_abs;
    logic [REG_BUS_W-1:0]    quot_fix, rem_fix;

    div_step u_step (
        .work_i    (work_q[DIV_WORK_W-2:0]),
        .divisor_i (divisor_q),
        .work_o    (step_work)
    );

    always_comb begin
        op1_abs  = (bus.signed_div_i && bus.opdata1_i[31]) ? neg32(bus.opdata1_i) : bus.opdata1_i;
        op2_abs  = (bus.signed_div_i && bus.opdata2_i[31]) ? neg32(bus.opdata2_i) : bus.opdata2_i;
        quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? neg32(work_q[31:0]) : work_q[31:0];
        rem_fix  = (signed_q && sign1_q) ? neg32(work_q[64:33]) : work_q[64:33];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = ZERO_RESULT;
                if (bus.start_i == DIV_START && !bus.annul_i) begin
                    signed_d  = bus.signed_div_i;
                    sign1_d   = bus.opdata1_i[31];
                    sign2_d   = bus.opdata2_i[31];
                    divisor_d = op2_abs;
                    work_d    = {ZERO_WORD, op1_abs, 1'b0};
                    cnt_d     = 6'd0;
                    state_d   = (bus.opdata2_i == ZERO_WORD) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                work_d  = '0;
                state_d = END;
            end
            ON: begin
                if (bus.annul_i) begin
                    cnt_d   = 6'd0;
                    state_d = FREE;
                end else if (cnt_q != DIV_CNT_DONE) begin
                    work_d = step_work;
                    cnt_d  = cnt_q + 6'd1;
                end else begin
                    // Bit 32 is a don't-care separator between remainder and quotient fields.
                    work_d  = {rem_fix, work_q[32], quot_fix};
                    cnt_d   = 6'd0;
                    state_d = END;
                end
            end
            END: begin
                if (bus.start_i == DIV_START) begin
                    result_d = {work_q[64:33], work_q[31:0]};
                    ready_d  = DIV_RESULT_READY;
                end else begin
                    result_d = ZERO_RESULT;
                    ready_d  = DIV_RESULT_NOT_READY;
                    state_d  = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= '0;
            divisor_q <= ZERO_WORD;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= ZERO_RESULT;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the iterative divider: expected results come from a
// 64-bit reference division and are matched against results as ready_o rises.
module tb_div;
    logic clk = 1'b0;
    logic rst;
    logic [63:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    div_if bus();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit chg5);
        int lat;
        int exp_lat;
        logic [63:0] exp, res;
        exp_lat = (b == 32'd0) ? 2 : 34;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        exp_q.push_back(model(sgn, a, b));
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (chg5 && c == 5) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sgn;
            end
            if (bus.ready_o) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            if (lat >= 0) begin
                chk({tag, "_res"}, bus.result_o, exp);
                res = bus.result_o;
                bus.opdata1_i = $urandom;
                bus.opdata2_i = $urandom | 32'd1;
                repeat (3) @(posedge clk);
                #1;
                chk({tag, "_hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, res[62:0]});
            end
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rel_rdy"}, 64'(bus.ready_o), 64'd0);
        chk({tag, "_rel_res"}, bus.result_o, 64'd0);
    endtask

    initial begin
        int seen;
        rst              = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #12;
        chk("reset_rdy", 64'(bus.ready_o), 64'd0);
        chk("reset_res", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("u_by0", 1'b0, 32'd12345, 32'd0, 1'b0);
        run_op("s_by0", 1'b1, 32'h8000_0000, 32'd0, 1'b0);

        // Annul mid-operation: nothing may come out, then a clean 9/3.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 9) begin
                bus.annul_i = 1'b1;
                bus.start_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) seen++;
        end
        chk("annul_quiet", 64'(seen), 64'd0);
        run_op("u9_3", 1'b0, 32'd9, 32'd3, 1'b0);

        // Reset mid-operation, then a fresh operation accepted on the first edge.
        @(negedge clk);
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_rdy", 64'(bus.ready_o), 64'd0);
        chk("rst_mid_res", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("s_neg_div", 1'b1, 32'd77, 32'hFFFF_FFF6, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_op("rand", 1'(i), $urandom, $urandom_range(32'hFFFF, 1), 1'b0);
        end

        // Asynchronous reset while a result is being held must clear it before any edge.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) begin
                seen = 1;
                break;
            end
        end
        chk("end_rdy", 64'(seen), 64'd1);
        chk("end_res", bus.result_o, model(1'b0, 32'd50, 32'd7));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_end_rdy", 64'(bus.ready_o), 64'd0);
        chk("rst_end_res", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
